// File: rtl/reg_file_if.sv
// Register file access bundle: writeback write port,
// two decode read ports and one debug read port.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wb_write_en;
  logic [ADDR_WIDTH-1:0] wb_write_addr;
  logic [DATA_WIDTH-1:0] wb_write_data;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output wb_write_en,
    output wb_write_addr,
    output wb_write_data,
    output rs1_addr,
    output rs2_addr,
    output dbg_addr,
    input  rs1_data,
    input  rs2_data,
    input  dbg_data
  );

  modport slave (
    input  wb_write_en,
    input  wb_write_addr,
    input  wb_write_data,
    input  rs1_addr,
    input  rs2_addr,
    input  dbg_addr,
    output rs1_data,
    output rs2_data,
    output dbg_data
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file x0..x31 with combinational reads
// and optional write-through bypass on the decode ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input logic         clk,
  input logic         rst,
  reg_file_if.slave   rf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] dbg;

  assign wr = rf.wb_write_en
           && (rf.wb_write_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr) begin
      regs[rf.wb_write_addr] <= rf.wb_write_data;
    end
  end

  // x0 check comes first so a bypassed write can never leak onto it
  always_comb begin
    rs1 = '0;
    if (rf.rs1_addr != '0) begin
      if (BYP && rf.wb_write_en
          && rf.wb_write_addr == rf.rs1_addr)
        rs1 = rf.wb_write_data;
      else
        rs1 = regs[rf.rs1_addr];
    end
  end

  always_comb begin
    rs2 = '0;
    if (rf.rs2_addr != '0) begin
      if (BYP && rf.wb_write_en
          && rf.wb_write_addr == rf.rs2_addr)
        rs2 = rf.wb_write_data;
      else
        rs2 = regs[rf.rs2_addr];
    end
  end

  always_comb begin
    dbg = '0;
    if (rf.dbg_addr != '0)
      dbg = regs[rf.dbg_addr];
  end

  assign rf.rs1_data = rs1;
  assign rf.rs2_data = rs2;
  assign rf.dbg_data = dbg;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: bypassing and non-bypassing instances
// share stimulus and are checked against an array model.
module tb_reg_file;
  logic clk = 0;
  logic rst = 0;
  int   total = 0;
  int   bad = 0;
  bit   valid = 0;

  logic [31:0] m [32];

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf1 ();
  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf0 ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1))
    dut1 (.clk(clk), .rst(rst), .rf(rf1.slave));
  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0))
    dut0 (.clk(clk), .rst(rst), .rf(rf0.slave));

  assign rf0.wb_write_en   = rf1.wb_write_en;
  assign rf0.wb_write_addr = rf1.wb_write_addr;
  assign rf0.wb_write_data = rf1.wb_write_data;
  assign rf0.rs1_addr      = rf1.rs1_addr;
  assign rf0.rs2_addr      = rf1.rs2_addr;
  assign rf0.dbg_addr      = rf1.dbg_addr;

  always #5 clk = ~clk;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_rd(
    input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && rf1.wb_write_en
        && rf1.wb_write_addr == a)
      return rf1.wb_write_data;
    return m[a];
  endfunction

  // model state commits on the same edge as the DUT
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 0;
      valid = 1;
    end else if (rf1.wb_write_en
                 && rf1.wb_write_addr != 0) begin
      m[rf1.wb_write_addr] = rf1.wb_write_data;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("b1_rs1", rf1.rs1_data,
          expect_rd(rf1.rs1_addr, 1));
      chk("b1_rs2", rf1.rs2_data,
          expect_rd(rf1.rs2_addr, 1));
      chk("b1_dbg", rf1.dbg_data,
          expect_rd(rf1.dbg_addr, 0));
      chk("b0_rs1", rf0.rs1_data,
          expect_rd(rf1.rs1_addr, 0));
      chk("b0_rs2", rf0.rs2_data,
          expect_rd(rf1.rs2_addr, 0));
      chk("b0_dbg", rf0.dbg_data,
          expect_rd(rf1.dbg_addr, 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic en, logic [4:0] a,
                    logic [31:0] d);
    rf1.wb_write_en   = en;
    rf1.wb_write_addr = a;
    rf1.wb_write_data = d;
  endtask

  task automatic rd(logic [4:0] a1, logic [4:0] a2,
                    logic [4:0] ad);
    rf1.rs1_addr = a1;
    rf1.rs2_addr = a2;
    rf1.dbg_addr = ad;
  endtask

  initial begin
    wr(0, 0, 0);
    rd(0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    rd(5, 31, 17);
    #2;
    chk("reset_rs1", rf1.rs1_data, 32'h0);
    chk("reset_rs2", rf1.rs2_data, 32'h0);
    chk("reset_dbg", rf1.dbg_data, 32'h0);

    // mid-stream reset
    wr(1, 5, 32'hDEADBEEF);
    step();
    wr(0, 0, 0);
    rd(5, 0, 5);
    #2;
    chk("pre_rst_dbg5", rf1.dbg_data, 32'hDEADBEEF);
    rst = 1;
    step();
    rst = 0;
    #2;
    chk("post_rst_rs1", rf1.rs1_data, 32'h0);
    chk("post_rst_dbg", rf1.dbg_data, 32'h0);

    wr(1, 3, 32'h12345678);
    step();
    wr(0, 0, 0);
    rd(3, 0, 3);
    #2;
    chk("wr3_rs1", rf1.rs1_data, 32'h12345678);
    chk("wr3_dbg", rf1.dbg_data, 32'h12345678);

    wr(1, 0, 32'hFFFFFFFF);
    rd(0, 0, 0);
    #2;
    chk("x0_pre_rs1", rf1.rs1_data, 32'h0);
    chk("x0_pre_rs2", rf1.rs2_data, 32'h0);
    step();
    wr(0, 0, 0);
    #2;
    chk("x0_post_rs1", rf1.rs1_data, 32'h0);
    chk("x0_post_dbg", rf1.dbg_data, 32'h0);

    wr(1, 7, 32'h1);
    step();
    wr(1, 7, 32'hAA);
    rd(7, 7, 7);
    #2;
    chk("byp1_rs1", rf1.rs1_data, 32'hAA);
    chk("byp1_rs2", rf1.rs2_data, 32'hAA);
    chk("byp1_dbg", rf1.dbg_data, 32'h1);
    chk("byp0_rs1", rf0.rs1_data, 32'h1);
    chk("byp0_rs2", rf0.rs2_data, 32'h1);
    step();
    wr(0, 0, 0);
    #2;
    chk("byp0_post", rf0.rs1_data, 32'hAA);

    wr(1, 9, 32'h77);
    step();
    rst = 1;
    wr(1, 9, 32'h55);
    step();
    rst = 0;
    wr(0, 0, 0);
    rd(9, 9, 9);
    #2;
    chk("rst_prio_dbg", rf1.dbg_data, 32'h0);
    chk("rst_prio_rs1", rf1.rs1_data, 32'h0);

    for (int i = 1; i < 32; i++) begin
      wr(1, 5'(i), 32'(i) * 32'h01010101);
      step();
    end
    wr(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i), 5'(i));
      #2;
      chk("sweep_rs1", rf1.rs1_data,
          32'(i) * 32'h01010101);
      chk("sweep_rs2", rf1.rs2_data,
          32'(31 - i) * 32'h01010101);
      step();
    end

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      wr(1'($urandom_range(0, 1)), a, $urandom);
      rd(($urandom_range(0, 3) == 0) ? a
           : 5'($urandom_range(0, 31)),
         ($urandom_range(0, 3) == 0) ? a
           : 5'($urandom_range(0, 31)),
         ($urandom_range(0, 3) == 0) ? a
           : 5'($urandom_range(0, 31)));
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0;
    wr(0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
